// File: rtl/spi_mem_pkg.sv
// SPI memory controller shared definitions.
// Opcodes carried in the top two bits of each command word.
package spi_mem_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mem_ram.sv
// Word storage for the SPI memory controller.
// One synchronous write port, one registered read port.
module spi_mem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read register: cleared on reset, holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n)  rd <= '0;
    else if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: command decode and address state.
// Storage and read data register live in spi_mem_ram.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        op;
  logic [DATA_W-1:0] pl;
  logic [ADDR_W-1:0] ld;
  logic              ld_ok;
  logic              is_wa, is_wd, is_ra, is_rd;
  logic              we, re;

  assign op    = din[DATA_W+1:DATA_W];
  assign pl    = din[DATA_W-1:0];
  assign ld    = din[ADDR_W-1:0];
  assign ld_ok = {1'b0, ld} < DEPTH_L;

  assign is_wa = op == OP_WR_ADDR;
  assign is_wd = op == OP_WR_DATA;
  assign is_ra = op == OP_RD_ADDR;
  assign is_rd = op == OP_RD_DATA;

  // Reset wins over any command in the same cycle.
  assign we = rst_n && rx_valid && is_wd;
  assign re = rst_n && rx_valid && is_rd;

  function automatic logic [ADDR_W-1:0] nxt(
    input logic [ADDR_W-1:0] a
  );
    if (AUTO_INC == 0) return a;
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  // Address registers, read strobe and sticky range error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      tx_valid <= re;
      if (rx_valid) begin
        unique case (1'b1)
          is_wa: begin
            if (ld_ok) wr_addr  <= ld;
            else       addr_err <= 1'b1;
          end
          is_wd: wr_addr <= nxt(wr_addr);
          is_ra: begin
            if (ld_ok) rd_addr  <= ld;
            else       addr_err <= 1'b1;
          end
          is_rd: rd_addr <= nxt(rd_addr);
          default: ;
        endcase
      end
    end
  end

  spi_mem_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .wa   (wr_addr),
    .wd   (pl),
    .re   (re),
    .ra   (rd_addr),
    .rd   (dout)
  );

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, memory word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits; ADDR_W <= DATA_W is required.
REQ-003 Parameter DEPTH, default 256, number of words; 1 < DEPTH <= 2**ADDR_W.
REQ-004 Parameter AUTO_INC, default 1, when 1 the address auto-increments after each data access.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] opcode, din[DATA_W-1:0] payload.
REQ-008 rx_valid  in  1  din qualifier; one command accepted per cycle when high.
REQ-009 dout  out  DATA_W  read data, registered.
REQ-010 tx_valid  out  1  dout valid strobe, one cycle per accepted read.
REQ-011 addr_err  out  1  sticky flag, out-of-range address load seen.

Function
REQ-012 Opcode 00 (WR_ADDR) SHALL load wr_addr from din[ADDR_W-1:0] at the accepting edge.
REQ-013 Opcode 01 (WR_DATA) SHALL write din[DATA_W-1:0] to mem[wr_addr]; if AUTO_INC, wr_addr SHALL advance by 1 at the same edge.
REQ-014 Opcode 10 (RD_ADDR) SHALL load rd_addr from din[ADDR_W-1:0]; wr_addr and rd_addr are independent registers.
REQ-015 Opcode 11 (RD_DATA) SHALL latch mem[rd_addr] into dout and assert tx_valid exactly one cycle after acceptance; if AUTO_INC, rd_addr SHALL advance by 1 at the accepting edge.
REQ-016 Back-to-back RD_DATA commands SHALL hold tx_valid high continuously, one new word per cycle.
REQ-017 dout SHALL hold its last value while tx_valid is low.
REQ-018 Auto-increment SHALL wrap from DEPTH-1 to 0 for both address registers.
REQ-019 An address load with payload >= DEPTH SHALL leave the target address register unchanged and set addr_err; addr_err clears only on reset.
REQ-020 RD_DATA accepted one cycle after WR_DATA to the same address SHALL return the newly written value (write-before-read ordering).
REQ-021 rx_valid low SHALL cause no state change except tx_valid falling after its one-cycle pulse.
REQ-022 Payload bits above ADDR_W SHALL be ignored for address loads.

Reset
REQ-023 With rst_n low at a rising edge: wr_addr=0, rd_addr=0, dout=0, tx_valid=0, addr_err=0.
REQ-024 Reset SHALL take priority over rx_valid; a read accepted in the cycle before reset SHALL NOT produce tx_valid after reset.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-026 Package spi_mem_pkg SHALL hold the opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA (2-bit).
REQ-027 Sub-module spi_mem_ram SHALL hold the storage: DATA_W x DEPTH, one synchronous write port, one synchronous read port, no reset.
REQ-028 The top level SHALL contain only command decode, address registers, the tx_valid register and addr_err.

Verification
REQ-029 Reset, WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> dout=0xA5, tx_valid high one cycle after RD_DATA only.
REQ-030 AUTO_INC=1: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33; RD_ADDR 0xFE, three consecutive RD_DATA -> dout 0x11, 0x22, 0x33 on consecutive cycles, tx_valid high for 3 cycles, and the third word sits at address 0x00 (wrap).
REQ-031 DEPTH=200: WR_ADDR 0xC8 -> addr_err=1, wr_addr unchanged; subsequent WR_DATA lands at previous wr_addr; addr_err stays 1 until rst_n low.
REQ-032 AUTO_INC=0: two RD_DATA at rd_addr 0x05 -> both return mem[0x05].
REQ-033 RD_DATA accepted, rst_n low next edge -> tx_valid=0, dout=0; memory word previously written still reads back after reset.
REQ-034 WR_DATA 0x5A at addr 3 then immediately RD_DATA at rd_addr 3 -> dout=0x5A.
